io_switch_cfg_loader: RTL and testbench



---
 rtl/io_switch_cfg_loader.sv | 116 +++++++++++
 tb/tb_io_switch_cfg_loader.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/io_switch_cfg_loader.sv
// Serial config loader: shifts in a PROG_W-bit word plus a 4-bit nibble-XOR checksum and commits it to prog only if the checksum matches.
// Latency: prog/cfg_done (or cfg_err) appear one cycle after the edge that samples the last checksum bit.
// Backpressure: none; the sender paces bits with cfg_valid, and cfg_valid=0 stalls the frame indefinitely.
module io_switch_cfg_loader #(
    parameter int PROG_W = 16   // multiple of 4, at least 4
) (
    input  logic              clb_clk,
    input  logic              clb_rst_n,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    input  logic              cfg_din,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic              prog_loaded,
    output logic [PROG_W-1:0] prog
);

    localparam int CW = $clog2(PROG_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CHK  = 2'd2,
        EVAL = 2'd3
    } state_t;

    state_t            state;
    logic [PROG_W-1:0] shadow;
    logic [CW-1:0]     bit_cnt;
    logic [3:0]        chk;
    logic [3:0]        exp_chk;

    // Expected checksum: XOR of every nibble of the shifted-in word.
    always_comb begin
        exp_chk = 4'h0;
        for (int i = 0; i < PROG_W / 4; i++) begin
            exp_chk = exp_chk ^ shadow[i*4 +: 4];
        end
    end

    // Busy is a pure decode of the state register, so it stays glitch-free.
    assign cfg_busy = (state != IDLE);

    // Frame FSM; prog is written only from EVAL so a partial word never leaks out.
    always_ff @(posedge clb_clk or negedge clb_rst_n) begin
        if (!clb_rst_n) begin
            state       <= IDLE;
            shadow      <= '0;
            bit_cnt     <= '0;
            chk         <= 4'h0;
            prog        <= '0;
            prog_loaded <= 1'b0;
            cfg_done    <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state   <= DATA;
                        shadow  <= '0;
                        bit_cnt <= '0;
                        chk     <= 4'h0;
                    end
                end
                DATA: begin
                    if (cfg_start) begin
                        // Abort and restart; the bit presented with start is dropped.
                        shadow  <= '0;
                        bit_cnt <= '0;
                        chk     <= 4'h0;
                    end else if (cfg_valid) begin
                        shadow <= {shadow[PROG_W-2:0], cfg_din};
                        if (bit_cnt == CW'(PROG_W - 1)) begin
                            bit_cnt <= '0;
                            state   <= CHK;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                CHK: begin
                    if (cfg_start) begin
                        state   <= DATA;
                        shadow  <= '0;
                        bit_cnt <= '0;
                        chk     <= 4'h0;
                    end else if (cfg_valid) begin
                        chk <= {chk[2:0], cfg_din};
                        if (bit_cnt == CW'(3)) begin
                            bit_cnt <= '0;
                            state   <= EVAL;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                EVAL: begin
                    // A start arriving here is ignored; evaluation always completes.
                    if (chk == exp_chk) begin
                        prog        <= shadow;
                        prog_loaded <= 1'b1;
                        cfg_done    <= 1'b1;
                    end else begin
                        cfg_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_switch_cfg_loader.sv
// Directed bench for io_switch_cfg_loader: frames, checksum errors, stalls, aborts and async reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Every frame is driven by the bench itself, so there is no backpressure to honour.
module tb_io_switch_cfg_loader;

    logic        clb_clk;
    logic        clb_rst_n;
    logic        cfg_start;
    logic        cfg_valid;
    logic        cfg_din;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;
    logic        prog_loaded;
    logic [15:0] prog;

    int n_tests;
    int n_fail;
    int busy_cyc;
    int done_cnt;
    int err_cnt;

    io_switch_cfg_loader #(.PROG_W(16)) dut (
        .clb_clk     (clb_clk),
        .clb_rst_n   (clb_rst_n),
        .cfg_start   (cfg_start),
        .cfg_valid   (cfg_valid),
        .cfg_din     (cfg_din),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .prog_loaded (prog_loaded),
        .prog        (prog)
    );

    initial clb_clk = 1'b0;
    always #5 clb_clk = ~clb_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, tally the outputs seen there, then drive new inputs.
    task automatic drive(input logic s, input logic v, input logic d);
        @(negedge clb_clk);
        if (cfg_busy) busy_cyc++;
        if (cfg_done) done_cnt++;
        if (cfg_err)  err_cnt++;
        cfg_start = s;
        cfg_valid = v;
        cfg_din   = d;
    endtask

    // Start pulse (optionally with valid/din), word MSB first, checksum, then one idle cycle
    // during which the DUT sits in EVAL. Stall gaps drive the inverted bit with valid low.
    task automatic send_frame(input logic [15:0] w, input logic [3:0] c, input int gap,
                              input logic sv, input logic sd);
        drive(1'b1, sv, sd);
        for (int i = 15; i >= 0; i--) begin
            drive(1'b0, 1'b1, w[i]);
            repeat (gap) drive(1'b0, 1'b0, ~w[i]);
        end
        for (int i = 3; i >= 0; i--) begin
            drive(1'b0, 1'b1, c[i]);
            if (i != 0) repeat (gap) drive(1'b0, 1'b0, ~c[i]);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    // Called right after send_frame: checks the EVAL cycle, then the result cycle.
    task automatic expect_result(input string tag, input logic done_e, input logic err_e,
                                 input logic [15:0] prog_e);
        check_val({tag, "_eval_busy"}, {31'b0, cfg_busy}, 32'd1);
        check_val({tag, "_eval_nodone"}, {31'b0, cfg_done}, 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        check_val({tag, "_done"}, {31'b0, cfg_done}, {31'b0, done_e});
        check_val({tag, "_err"},  {31'b0, cfg_err},  {31'b0, err_e});
        check_val({tag, "_busy0"}, {31'b0, cfg_busy}, 32'd0);
        check_val({tag, "_prog"}, {16'b0, prog}, {16'b0, prog_e});
        drive(1'b0, 1'b0, 1'b0);
        check_val({tag, "_pulse_end"}, {30'b0, cfg_done, cfg_err}, 32'd0);
    endtask

    initial begin
        int err_before;
        n_tests   = 0;
        n_fail    = 0;
        busy_cyc  = 0;
        done_cnt  = 0;
        err_cnt   = 0;
        clb_rst_n = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_din   = 1'b0;

        // Reset values
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check_val("rst_prog",   {16'b0, prog}, 32'h0);
        check_val("rst_flags",  {28'b0, cfg_busy, cfg_done, cfg_err, prog_loaded}, 32'h0);
        clb_rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b1);   // valid in IDLE is ignored
        drive(1'b0, 1'b0, 1'b0);
        check_val("idle_ignore_valid", {31'b0, cfg_busy}, 32'd0);

        // 1: basic load, busy spans 21 cycles
        busy_cyc = 0;
        send_frame(16'h1234, 4'h4, 0, 1'b0, 1'b0);
        expect_result("t1", 1'b1, 1'b0, 16'h1234);
        check_val("t1_busy_cycles", busy_cyc, 32'd21);
        check_val("t1_loaded", {31'b0, prog_loaded}, 32'd1);

        // 2: bad checksum leaves prog alone
        send_frame(16'hA5C3, 4'h5, 0, 1'b0, 1'b0);
        expect_result("t2", 1'b0, 1'b1, 16'h1234);
        check_val("t2_loaded", {31'b0, prog_loaded}, 32'd1);

        // 3: stalled frame, inverted bits during gaps must not be captured
        send_frame(16'hFFFF, 4'h0, 3, 1'b0, 1'b0);
        expect_result("t3", 1'b1, 1'b0, 16'hFFFF);

        // 4: abort after 8 bits, then a full frame; no error pulse
        err_before = err_cnt;
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 15; i >= 8; i--) drive(1'b0, 1'b1, 1'b0);
        check_val("t4_prog_held", {16'b0, prog}, 32'hFFFF);
        send_frame(16'h8001, 4'h9, 0, 1'b0, 1'b0);
        expect_result("t4", 1'b1, 1'b0, 16'h8001);
        check_val("t4_no_err", err_cnt - err_before, 32'd0);

        // 5: asynchronous reset mid-frame
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 15; i >= 10; i--) drive(1'b0, 1'b1, (16'h1234 >> i) & 1);
        check_val("t5_no_partial", {16'b0, prog}, 32'h8001);
        #2 clb_rst_n = 1'b0;
        #1;
        check_val("t5_rst_prog",  {16'b0, prog}, 32'h0);
        check_val("t5_rst_flags", {29'b0, cfg_busy, prog_loaded, cfg_done}, 32'h0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        clb_rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        check_val("t5_idle", {31'b0, cfg_busy}, 32'd0);
        send_frame(16'h0F0F, 4'h0, 0, 1'b0, 1'b0);
        expect_result("t5", 1'b1, 1'b0, 16'h0F0F);
        check_val("t5_loaded", {31'b0, prog_loaded}, 32'd1);

        // 6: start with valid=1, din=1 must not shift in a bit
        send_frame(16'h0001, 4'h1, 0, 1'b1, 1'b1);
        expect_result("t6", 1'b1, 1'b0, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
